mem_access_ctrl: RTL and testbench

Sequences MEM-stage loads/stores onto the data SRAM bus (req / addr_ok / data_ok handshake) and generates the MEM-stage stall.
- Formats store data and byte strobes; aligns and extends load data; flags misaligned accesses.
- Drains an outstanding transaction when the pipeline is flushed.
- Sits between the MEM pipeline stage and the data-side SRAM interface.

---
 rtl/mem_access_ctrl_pkg.sv | 46 ++++
 rtl/mem_align_fmt.sv | 68 ++++++
 rtl/mem_access_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-bus sequencer: memop codes,
// access sizes, FSM states and small op-decode helpers.
package mem_access_ctrl_pkg;

  localparam int MMOP_W = 4;

  localparam logic [MMOP_W-1:0] MEMOP_NOP = 4'd0;
  localparam logic [MMOP_W-1:0] MEMOP_LB  = 4'd1;
  localparam logic [MMOP_W-1:0] MEMOP_LBU = 4'd2;
  localparam logic [MMOP_W-1:0] MEMOP_LH  = 4'd3;
  localparam logic [MMOP_W-1:0] MEMOP_LHU = 4'd4;
  localparam logic [MMOP_W-1:0] MEMOP_LW  = 4'd5;
  localparam logic [MMOP_W-1:0] MEMOP_SB  = 4'd6;
  localparam logic [MMOP_W-1:0] MEMOP_SH  = 4'd7;
  localparam logic [MMOP_W-1:0] MEMOP_SW  = 4'd8;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_CANCEL = 3'd4
  } state_e;

  function automatic logic is_load(input logic [MMOP_W-1:0] op);
    return (op == MEMOP_LB) || (op == MEMOP_LBU) || (op == MEMOP_LH) ||
           (op == MEMOP_LHU) || (op == MEMOP_LW);
  endfunction

  function automatic logic is_store(input logic [MMOP_W-1:0] op);
    return (op == MEMOP_SB) || (op == MEMOP_SH) || (op == MEMOP_SW);
  endfunction

  function automatic logic [1:0] op_size(input logic [MMOP_W-1:0] op);
    case (op)
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: return SIZE_HALF;
      MEMOP_LW, MEMOP_SW:            return SIZE_WORD;
      default:                       return SIZE_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/mem_align_fmt.sv
// Combinational formatting for the data bus: store strobes and lane
// replication, load lane extraction with sign/zero extension, misalign check.
module mem_align_fmt
  import mem_access_ctrl_pkg::*;
(
  input  logic [MMOP_W-1:0] i_st_op,
  input  logic [1:0]        i_st_addr_lo,
  input  logic [31:0]       i_st_wdata,
  output logic [3:0]        o_wstrb,
  output logic [31:0]       o_wdata,
  output logic              o_adel,
  output logic              o_ades,
  input  logic [MMOP_W-1:0] i_ld_op,
  input  logic [1:0]        i_ld_addr_lo,
  input  logic [31:0]       i_ld_rdata,
  output logic [31:0]       o_ld_result
);

  logic        w_half;
  logic        w_word;
  logic        w_mis;
  logic [31:0] w_shift;

  assign w_half = (i_st_op == MEMOP_LH) || (i_st_op == MEMOP_LHU) || (i_st_op == MEMOP_SH);
  assign w_word = (i_st_op == MEMOP_LW) || (i_st_op == MEMOP_SW);
  assign w_mis  = (w_half && i_st_addr_lo[0]) || (w_word && (i_st_addr_lo != 2'b00));

  assign o_adel = w_mis && is_load(i_st_op);
  assign o_ades = w_mis && is_store(i_st_op);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    o_wstrb = 4'b0000;
    o_wdata = 32'h0;
    case (i_st_op)
      MEMOP_SB: begin
        o_wstrb = 4'b0001 << i_st_addr_lo;
        o_wdata = {4{i_st_wdata[7:0]}};
      end
      MEMOP_SH: begin
        o_wstrb = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_st_wdata[15:0]}};
      end
      MEMOP_SW: begin
        o_wstrb = 4'b1111;
        o_wdata = i_st_wdata;
      end
      default: ;
    endcase
  end

  // The addressed lane is moved down to bit 0 before extension.
  assign w_shift = i_ld_rdata >> {i_ld_addr_lo, 3'b000};

  always_comb begin
    o_ld_result = 32'h0;
    case (i_ld_op)
      MEMOP_LB:  o_ld_result = {{24{w_shift[7]}}, w_shift[7:0]};
      MEMOP_LBU: o_ld_result = {24'h0, w_shift[7:0]};
      MEMOP_LH:  o_ld_result = {{16{w_shift[15]}}, w_shift[15:0]};
      MEMOP_LHU: o_ld_result = {16'h0, w_shift[15:0]};
      MEMOP_LW:  o_ld_result = i_ld_rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer for the req/addr_ok/data_ok SRAM bus.
// Optional performance counters are enabled with MEM_ACCESS_PERF_EN.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [MMOP_W-1:0] req_op,
  input  logic [AW-1:0]     req_addr,
  input  logic [DW-1:0]     req_wdata,
  input  logic              flush,
  input  logic              down_stall,
  output logic              mem_stall_o,
  output logic [DW-1:0]     rdata_o,
  output logic              rdata_valid_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [AW-1:0]     data_addr,
  output logic [DW-1:0]     data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic [DW-1:0]     data_rdata,
  input  logic              data_data_ok
`ifdef MEM_ACCESS_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [15:0]       perf_cancel_cnt
`endif
);

  state_e              r_state;
  state_e              w_next;

  logic [MMOP_W-1:0]   r_op;
  logic [AW-1:0]       r_addr;
  logic                r_wr;
  logic [1:0]          r_size;
  logic [DW-1:0]       r_wdata;
  logic [3:0]          r_wstrb;
  logic [DW-1:0]       r_rdata;

  logic [3:0]          w_st_wstrb;
  logic [DW-1:0]       w_st_wdata;
  logic                w_adel;
  logic                w_ades;
  logic [DW-1:0]       w_ld_result;
  logic                w_accept;

  mem_align_fmt u_fmt (
    .i_st_op      (req_op),
    .i_st_addr_lo (req_addr[1:0]),
    .i_st_wdata   (req_wdata),
    .o_wstrb      (w_st_wstrb),
    .o_wdata      (w_st_wdata),
    .o_adel       (w_adel),
    .o_ades       (w_ades),
    .i_ld_op      (r_op),
    .i_ld_addr_lo (r_addr[1:0]),
    .i_ld_rdata   (data_rdata),
    .o_ld_result  (w_ld_result)
  );

  // Misaligned ops and NOPs never reach the bus; a flush cancels the launch.
  assign w_accept = (r_state == ST_IDLE) && req_valid &&
                    (is_load(req_op) || is_store(req_op)) &&
                    !w_adel && !w_ades && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values, independent of block order.
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_REQ;
      ST_REQ: begin
        if (data_addr_ok && flush) w_next = ST_CANCEL;
        else if (data_addr_ok)     w_next = ST_WAIT;
        else if (flush)            w_next = ST_IDLE;
      end
      ST_WAIT: begin
        if (data_data_ok && flush) w_next = ST_IDLE;
        else if (data_data_ok)     w_next = ST_DONE;
        else if (flush)            w_next = ST_CANCEL;
      end
      ST_DONE:   if (flush || !down_stall) w_next = ST_IDLE;
      ST_CANCEL: if (data_data_ok) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, whatever the pipeline presents.
  always_comb begin
    mem_stall_o   = 1'b0;
    rdata_valid_o = 1'b0;
    rdata_o       = '0;
    adel_o        = 1'b0;
    ades_o        = 1'b0;
    data_req      = 1'b0;
    if (rst_n) begin
      case (r_state)
        ST_IDLE: begin
          adel_o      = req_valid && w_adel;
          ades_o      = req_valid && w_ades;
          mem_stall_o = w_accept;
        end
        ST_REQ: begin
          data_req    = 1'b1;
          mem_stall_o = 1'b1;
        end
        ST_WAIT: mem_stall_o = 1'b1;
        ST_DONE: begin
          rdata_valid_o = is_load(r_op);
          rdata_o       = is_load(r_op) ? r_rdata : '0;
        end
        ST_CANCEL: mem_stall_o = req_valid;
        default: ;
      endcase
    end
  end

  assign data_wr    = r_wr;
  assign data_size  = r_size;
  assign data_addr  = r_addr;
  assign data_wdata = r_wdata;
  assign data_wstrb = r_wstrb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= MEMOP_NOP;
      r_addr  <= '0;
      r_wr    <= 1'b0;
      r_size  <= SIZE_BYTE;
      r_wdata <= '0;
      r_wstrb <= 4'b0000;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= req_op;
        r_addr  <= req_addr;
        r_wr    <= is_store(req_op);
        r_size  <= op_size(req_op);
        r_wdata <= w_st_wdata;
        r_wstrb <= w_st_wstrb;
      end
      // A response that coincides with a flush belongs to a dead instruction.
      if ((r_state == ST_WAIT) && data_data_ok && !flush) r_rdata <= w_ld_result;
    end
  end

`ifdef MEM_ACCESS_PERF_EN
  logic [31:0] r_perf_stall_cnt;
  logic [15:0] r_perf_cancel_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall_cnt  <= '0;
      r_perf_cancel_cnt <= '0;
    end else begin
      if (mem_stall_o && (r_perf_stall_cnt != '1))
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      if ((r_state != ST_CANCEL) && (w_next == ST_CANCEL) && (r_perf_cancel_cnt != '1))
        r_perf_cancel_cnt <= r_perf_cancel_cnt + 16'd1;
    end
  end

  assign perf_stall_cnt  = r_perf_stall_cnt;
  assign perf_cancel_cnt = r_perf_cancel_cnt;
`else
  // Without the counters, stall and cancel events are not observed here.
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: store/load formatting, misalign,
// flush/cancel paths, down_stall hold and asynchronous reset.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        flush;
  logic        down_stall;
  logic        mem_stall_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        adel_o;
  logic        ades_o;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic [31:0] data_rdata;
  logic        data_data_ok;

  int n_checks = 0;
  int n_pass   = 0;

  mem_access_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .flush         (flush),
    .down_stall    (down_stall),
    .mem_stall_o   (mem_stall_o),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .adel_o        (adel_o),
    .ades_o        (ades_o),
    .data_req      (data_req),
    .data_wr       (data_wr),
    .data_size     (data_size),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_wstrb    (data_wstrb),
    .data_addr_ok  (data_addr_ok),
    .data_rdata    (data_rdata),
    .data_data_ok  (data_data_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_idle();
    req_valid    = 1'b0;
    req_op       = MEMOP_NOP;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    flush        = 1'b0;
    down_stall   = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;
  endtask

  task automatic present(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  // Fastest handshake: addr_ok in the REQ cycle, data_ok in the first WAIT cycle.
  task automatic simple_op(input string tag, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input logic exp_wr, input logic [1:0] exp_size,
                           input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                           input logic exp_rvalid, input logic [31:0] exp_rdata);
    cyc(); present(op, addr, wdata); #1;
    check({tag, ".t0_stall"}, mem_stall_o, 1);
    check({tag, ".t0_req"}, data_req, 0);
    cyc(); data_addr_ok = 1'b1; #1;
    check({tag, ".t1_req"}, data_req, 1);
    check({tag, ".t1_stall"}, mem_stall_o, 1);
    check({tag, ".wr"}, data_wr, exp_wr);
    check({tag, ".size"}, data_size, exp_size);
    check({tag, ".addr"}, data_addr, addr);
    check({tag, ".wstrb"}, data_wstrb, exp_wstrb);
    if (exp_wr) check({tag, ".wdata"}, data_wdata, exp_wdata);
    cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = rdata; #1;
    check({tag, ".t2_stall"}, mem_stall_o, 1);
    check({tag, ".t2_req"}, data_req, 0);
    cyc(); data_data_ok = 1'b0; data_rdata = 32'h0; #1;
    check({tag, ".t3_stall"}, mem_stall_o, 0);
    check({tag, ".t3_rvalid"}, rdata_valid_o, exp_rvalid);
    check({tag, ".t3_rdata"}, rdata_o, exp_rdata);
    cyc(); set_idle(); #1;
    check({tag, ".t4_rvalid"}, rdata_valid_o, 0);
    check({tag, ".t4_req"}, data_req, 0);
  endtask

  initial begin
    set_idle();
    rst_n = 1'b0;
    #3;
    check("rst.stall", mem_stall_o, 0);
    check("rst.req", data_req, 0);
    check("rst.rvalid", rdata_valid_o, 0);
    check("rst.wstrb", data_wstrb, 0);
    cyc(); cyc(); rst_n = 1'b1;

    simple_op("sw",  MEMOP_SW,  32'h1000, 32'hDEADBEEF, 32'h0,        1, 2, 4'b1111, 32'hDEADBEEF, 0, 32'h0);
    simple_op("lb",  MEMOP_LB,  32'h2003, 32'h0,        32'h80FF0000, 0, 0, 4'b0000, 32'h0, 1, 32'hFFFFFF80);
    simple_op("lbu", MEMOP_LBU, 32'h2003, 32'h0,        32'h80FF0000, 0, 0, 4'b0000, 32'h0, 1, 32'h00000080);
    simple_op("lbp", MEMOP_LB,  32'h2001, 32'h0,        32'h00007F00, 0, 0, 4'b0000, 32'h0, 1, 32'h0000007F);
    simple_op("sh",  MEMOP_SH,  32'h3002, 32'h1234ABCD, 32'h0,        1, 1, 4'b1100, 32'hABCDABCD, 0, 32'h0);
    simple_op("sb",  MEMOP_SB,  32'h7001, 32'h000000A5, 32'h0,        1, 0, 4'b0010, 32'hA5A5A5A5, 0, 32'h0);
    simple_op("lh",  MEMOP_LH,  32'h5002, 32'h0,        32'h80011234, 0, 1, 4'b0000, 32'h0, 1, 32'hFFFF8001);
    simple_op("lhu", MEMOP_LHU, 32'h5000, 32'h0,        32'h8001F00D, 0, 1, 4'b0000, 32'h0, 1, 32'h0000F00D);
    simple_op("lw",  MEMOP_LW,  32'h6000, 32'h0,        32'h12345678, 0, 2, 4'b0000, 32'h0, 1, 32'h12345678);

    // Misaligned and NOP requests never stall and never reach the bus.
    cyc(); present(MEMOP_LW, 32'h4002, 32'h0); #1;
    check("mis_lw.adel", adel_o, 1);
    check("mis_lw.ades", ades_o, 0);
    check("mis_lw.stall", mem_stall_o, 0);
    check("mis_lw.req", data_req, 0);
    cyc(); #1;
    check("mis_lw.req_next", data_req, 0);
    cyc(); present(MEMOP_SH, 32'h4001, 32'h1111); #1;
    check("mis_sh.ades", ades_o, 1);
    check("mis_sh.adel", adel_o, 0);
    check("mis_sh.stall", mem_stall_o, 0);
    cyc(); present(MEMOP_SW, 32'h4003, 32'h2222); #1;
    check("mis_sw.ades", ades_o, 1);
    cyc(); present(MEMOP_NOP, 32'h4001, 32'h0); #1;
    check("nop.stall", mem_stall_o, 0);
    check("nop.adel", adel_o, 0);
    cyc(); #1;
    check("nop.req_next", data_req, 0);
    cyc(); set_idle(); #1;

    // Flush while WAITing: cancel, discard 0x55, then a fresh load completes.
    cyc(); present(MEMOP_LW, 32'h8000, 32'h0); #1;
    check("cw.t0_stall", mem_stall_o, 1);
    cyc(); data_addr_ok = 1'b1; #1;
    check("cw.t1_req", data_req, 1);
    cyc(); data_addr_ok = 1'b0; flush = 1'b1; #1;
    check("cw.t2_stall", mem_stall_o, 1);
    check("cw.t2_rvalid", rdata_valid_o, 0);
    cyc(); flush = 1'b0; req_valid = 1'b0; #1;
    check("cw.t3_stall", mem_stall_o, 0);
    check("cw.t3_req", data_req, 0);
    check("cw.t3_rvalid", rdata_valid_o, 0);
    cyc(); present(MEMOP_LW, 32'h9000, 32'h0); #1;
    check("cw.t4_stall", mem_stall_o, 1);
    check("cw.t4_req", data_req, 0);
    cyc(); data_data_ok = 1'b1; data_rdata = 32'h55; #1;
    check("cw.t5_stall", mem_stall_o, 1);
    check("cw.t5_rvalid", rdata_valid_o, 0);
    cyc(); data_data_ok = 1'b0; data_rdata = 32'h0; #1;
    check("cw.t6_stall", mem_stall_o, 1);
    check("cw.t6_rvalid", rdata_valid_o, 0);
    cyc(); data_addr_ok = 1'b1; #1;
    check("cw.t7_req", data_req, 1);
    check("cw.t7_addr", data_addr, 32'h9000);
    cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFEF00D; #1;
    check("cw.t8_stall", mem_stall_o, 1);
    cyc(); data_data_ok = 1'b0; data_rdata = 32'h0; #1;
    check("cw.t9_rvalid", rdata_valid_o, 1);
    check("cw.t9_rdata", rdata_o, 32'hCAFEF00D);
    cyc(); set_idle(); #1;
    check("cw.t10_rvalid", rdata_valid_o, 0);

    // down_stall holds DONE for two extra cycles with a stable result.
    cyc(); present(MEMOP_LW, 32'hB004, 32'h0); #1;
    check("ds.t0_stall", mem_stall_o, 1);
    cyc(); data_addr_ok = 1'b1; #1;
    check("ds.t1_req", data_req, 1);
    cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h13572468; #1;
    check("ds.t2_stall", mem_stall_o, 1);
    cyc(); data_data_ok = 1'b0; data_rdata = 32'hFFFFFFFF; down_stall = 1'b1; #1;
    check("ds.t3_rvalid", rdata_valid_o, 1);
    check("ds.t3_rdata", rdata_o, 32'h13572468);
    check("ds.t3_stall", mem_stall_o, 0);
    cyc(); #1;
    check("ds.t4_rvalid", rdata_valid_o, 1);
    check("ds.t4_rdata", rdata_o, 32'h13572468);
    cyc(); down_stall = 1'b0; #1;
    check("ds.t5_rvalid", rdata_valid_o, 1);
    check("ds.t5_rdata", rdata_o, 32'h13572468);
    cyc(); set_idle(); #1;
    check("ds.t6_rvalid", rdata_valid_o, 0);

    // Flush with addr_ok -> CANCEL; flush in REQ without addr_ok -> dropped.
    cyc(); present(MEMOP_LW, 32'hC000, 32'h0); #1;
    check("fr.t0_stall", mem_stall_o, 1);
    cyc(); data_addr_ok = 1'b1; flush = 1'b1; #1;
    check("fr.t1_req", data_req, 1);
    check("fr.t1_stall", mem_stall_o, 1);
    cyc(); data_addr_ok = 1'b0; flush = 1'b0; present(MEMOP_SW, 32'hD000, 32'h11223344); #1;
    check("fr.t2_stall", mem_stall_o, 1);
    check("fr.t2_req", data_req, 0);
    cyc(); #1;
    check("fr.t3_req", data_req, 0);
    check("fr.t3_stall", mem_stall_o, 1);
    cyc(); data_data_ok = 1'b1; #1;
    check("fr.t4_req", data_req, 0);
    cyc(); data_data_ok = 1'b0; #1;
    check("fr.t5_stall", mem_stall_o, 1);
    cyc(); flush = 1'b1; #1;
    check("fr.t6_req", data_req, 1);
    check("fr.t6_addr", data_addr, 32'hD000);
    check("fr.t6_wstrb", data_wstrb, 4'b1111);
    cyc(); flush = 1'b0; present(MEMOP_LW, 32'hA000, 32'h0); #1;
    check("fr.t7_stall", mem_stall_o, 1);
    check("fr.t7_req", data_req, 0);
    cyc(); data_addr_ok = 1'b1; #1;
    check("fr.t8_req", data_req, 1);
    check("fr.t8_addr", data_addr, 32'hA000);
    cyc(); data_addr_ok = 1'b0; #1;
    check("fr.t9_stall", mem_stall_o, 1);
    check("fr.t9_req", data_req, 0);

    // Asynchronous reset in the middle of WAIT.
    #2 rst_n = 1'b0;
    #1;
    check("arst.stall", mem_stall_o, 0);
    check("arst.req", data_req, 0);
    check("arst.rvalid", rdata_valid_o, 0);
    check("arst.rdata", rdata_o, 0);
    check("arst.addr", data_addr, 0);
    check("arst.wr", data_wr, 0);
    check("arst.size", data_size, 0);
    check("arst.wstrb", data_wstrb, 0);
    check("arst.wdata", data_wdata, 0);
    check("arst.adel", adel_o, 0);
    cyc(); rst_n = 1'b1; set_idle(); #1;
    check("post.stall", mem_stall_o, 0);
    check("post.req", data_req, 0);
    cyc(); #1;
    check("post.req_next", data_req, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
